// File: rtl/eight_bit_serial_comparator.sv
// Purpose: MSB-first serial magnitude comparator, DIGIT bits per clock, unsigned or two's-complement.
// Latency: done pulses the cycle after the deciding edge; at most WIDTH/DIGIT edges after acceptance.
// Backpressure: none; start is only sampled in IDLE/DONE, and requests while busy are dropped.
module eight_bit_serial_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AgB,
    output logic             BgA,
    output logic             AeB
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             agb_q, agb_d;
    logic             bga_q, bga_d;
    logic             aeb_q, aeb_d;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;

    // Current top digit of each operand; in signed mode the sign bit of the
    // leading digit is flipped so the unsigned digit compare orders negatives first.
    always_comb begin
        dig_a = a_q[WIDTH-1 -: DIGIT];
        dig_b = b_q[WIDTH-1 -: DIGIT];
        if (mode_q && (cnt_q == '0)) begin
            dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
            dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
        end
    end

    // Next-state, operand shifting and result decision.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        agb_d   = agb_q;
        bga_d   = bga_q;
        aeb_d   = aeb_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    mode_d  = signed_mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (dig_a != dig_b) begin
                    // First differing digit decides; lower digits are irrelevant.
                    agb_d   = (dig_a > dig_b);
                    bga_d   = (dig_b > dig_a);
                    aeb_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CW'(NDIG - 1)) begin
                    agb_d   = 1'b0;
                    bga_d   = 1'b0;
                    aeb_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything including results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            agb_q   <= 1'b0;
            bga_q   <= 1'b0;
            aeb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            agb_q   <= agb_d;
            bga_q   <= bga_d;
            aeb_q   <= aeb_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign AgB  = agb_q;
    assign BgA  = bga_q;
    assign AeB  = aeb_q;

endmodule
